// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: shared colour defaults and the layer-pair bit index.
package space_invaders_pkg;
  localparam int DEFAULT_RGB_WIDTH = 8;
  localparam logic [7:0] DEFAULT_TRANSPARENT_RGB = 8'hFF;
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction
endpackage

// File: rtl/object_compositor_if.sv
// object_compositor_if: pixel inputs and composited/collision outputs of the compositor.
interface object_compositor_if import space_invaders_pkg::*; #(
  parameter int NUM_OBJECTS = 4,
  parameter int RGB_WIDTH   = DEFAULT_RGB_WIDTH
);
  localparam int NUM_PAIRS = NUM_OBJECTS * (NUM_OBJECTS - 1) / 2;
  logic                                  startOfFrame;
  logic [NUM_OBJECTS-1:0]                draw_requests;
  logic [NUM_OBJECTS-1:0][RGB_WIDTH-1:0] obj_RGB;
  logic [RGB_WIDTH-1:0]                  background_RGB;
  logic [NUM_OBJECTS-1:0]                layer_enable;
  logic [RGB_WIDTH-1:0]                  out_RGB;
  logic [NUM_PAIRS-1:0]                  frame_collisions;
  logic                                  collision_pulse;
  logic [15:0]                           frame_count;
  modport master (
    output startOfFrame, draw_requests, obj_RGB, background_RGB, layer_enable,
    input  out_RGB, frame_collisions, collision_pulse, frame_count
  );
  modport slave (
    input  startOfFrame, draw_requests, obj_RGB, background_RGB, layer_enable,
    output out_RGB, frame_collisions, collision_pulse, frame_count
  );
endinterface

// File: rtl/pair_collision_detect.sv
// pair_collision_detect: per-pair overlap detection, per-frame sticky accumulation and publish.
module pair_collision_detect import space_invaders_pkg::*; #(
  parameter int NUM_OBJECTS = 4,
  parameter int NUM_PAIRS   = NUM_OBJECTS * (NUM_OBJECTS - 1) / 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [NUM_OBJECTS-1:0] active,
  output logic [NUM_PAIRS-1:0]   frame_collisions,
  output logic                   collision_pulse
);
  logic [NUM_PAIRS-1:0] hits;
  logic [NUM_PAIRS-1:0] acc;
  logic                 new_hit;
  for (genvar i = 0; i < NUM_OBJECTS - 1; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_OBJECTS; j++) begin : g_j
      assign hits[pair_index(i, j, NUM_OBJECTS)] = active[i] & active[j];
    end
  end
  assign new_hit = |(hits & ~acc);
  // Hits in the frame-start cycle close the old frame and also open the new one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc              <= '0;
      frame_collisions <= '0;
      collision_pulse  <= 1'b0;
    end else begin
      collision_pulse <= new_hit;
      acc             <= startOfFrame ? hits : (acc | hits);
      if (startOfFrame) frame_collisions <= acc | hits;
    end
  end
endmodule

// File: rtl/object_compositor.sv
// object_compositor: priority-composites object layers over a background and tracks pair collisions.
module object_compositor import space_invaders_pkg::*; #(
  parameter int                   NUM_OBJECTS     = 4,
  parameter int                   RGB_WIDTH       = DEFAULT_RGB_WIDTH,
  parameter logic [RGB_WIDTH-1:0] TRANSPARENT_RGB = RGB_WIDTH'(DEFAULT_TRANSPARENT_RGB)
) (
  input logic               clk,
  input logic               resetN,
  object_compositor_if.slave bus
);
  localparam int NUM_PAIRS = NUM_OBJECTS * (NUM_OBJECTS - 1) / 2;
  logic [NUM_OBJECTS-1:0]                active;
  logic [NUM_OBJECTS:0][RGB_WIDTH-1:0]   chain;
  assign chain[NUM_OBJECTS] = bus.background_RGB;
  // Chain from the lowest-priority end so index 0 wins last.
  for (genvar i = 0; i < NUM_OBJECTS; i++) begin : g_layer
    assign active[i] = bus.draw_requests[i] & bus.layer_enable[i] & (bus.obj_RGB[i] != TRANSPARENT_RGB);
    assign chain[i]  = active[i] ? bus.obj_RGB[i] : chain[i+1];
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.out_RGB     <= '0;
      bus.frame_count <= '0;
    end else begin
      bus.out_RGB <= chain[0];
      if (bus.startOfFrame) bus.frame_count <= bus.frame_count + 16'd1;
    end
  end
  pair_collision_detect #(.NUM_OBJECTS(NUM_OBJECTS), .NUM_PAIRS(NUM_PAIRS)) u_pcd (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (bus.startOfFrame),
    .active           (active),
    .frame_collisions (bus.frame_collisions),
    .collision_pulse  (bus.collision_pulse)
  );
endmodule

// File: tb/tb_object_compositor.sv
// tb_object_compositor: directed and randomized checks of object_compositor against a frame-level model.
module tb_object_compositor;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;
  object_compositor_if #(.NUM_OBJECTS(4), .RGB_WIDTH(8)) bus();
  object_compositor #(.NUM_OBJECTS(4), .RGB_WIDTH(8), .TRANSPARENT_RGB(8'hFF)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  m_out;
  logic [5:0]  m_fc, m_acc;
  logic        m_pulse;
  logic [15:0] m_cnt;

  task automatic model_clear();
    m_out = '0; m_fc = '0; m_acc = '0; m_pulse = 1'b0; m_cnt = '0;
  endtask

  // Advance one clock; the model sees the inputs present before the edge.
  task automatic tick();
    bit         act[4];
    bit         found;
    logic [5:0] h;
    logic [7:0] pix;
    logic [7:0] rgb[4];
    logic       sof;
    sof = bus.startOfFrame;
    h = '0;
    found = 0;
    pix = bus.background_RGB;
    for (int i = 0; i < 4; i++) rgb[i] = bus.obj_RGB[i];
    for (int i = 0; i < 4; i++) act[i] = bus.draw_requests[i] && bus.layer_enable[i] && rgb[i] != 8'hFF;
    for (int i = 0; i < 4; i++) if (act[i] && !found) begin pix = rgb[i]; found = 1; end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (act[i] && act[j]) h[i*4 - i*(i+1)/2 + (j-i-1)] = 1'b1;
    @(posedge clk);
    if (resetN) begin
      m_pulse = |(h & ~m_acc);
      m_out = pix;
      if (sof) begin
        m_cnt = m_cnt + 16'd1;
        m_fc = m_acc | h;
        m_acc = h;
      end else m_acc = m_acc | h;
    end
    #1;
  endtask

  task automatic sof_tick();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.draw_requests = '0;
    bus.obj_RGB = '0;
    bus.background_RGB = '0;
    bus.layer_enable = '0;
    model_clear();
    #12;
    n_checks++; if (bus.out_RGB !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h want 00", bus.out_RGB); end
    n_checks++; if (bus.frame_collisions !== 6'b0) begin n_fail++; $display("FAIL reset_fc got %b want 000000", bus.frame_collisions); end
    n_checks++; if (bus.collision_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", bus.collision_pulse); end
    n_checks++; if (bus.frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", bus.frame_count); end
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  task automatic test_priority();
    bus.layer_enable = 4'b1111;
    bus.background_RGB = 8'h03;
    bus.obj_RGB = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.draw_requests = 4'b0110;
    tick();
    n_checks++; if (bus.out_RGB !== 8'h20) begin n_fail++; $display("FAIL prio_0110 got %h want 20", bus.out_RGB); end
    bus.draw_requests = 4'b0000;
    #1;
    n_checks++; if (bus.out_RGB !== 8'h20) begin n_fail++; $display("FAIL prio_latency got %h want 20", bus.out_RGB); end
    tick();
    n_checks++; if (bus.out_RGB !== 8'h03) begin n_fail++; $display("FAIL prio_bg got %h want 03", bus.out_RGB); end
  endtask

  task automatic test_mask();
    bus.draw_requests = 4'b0000;
    sof_tick();
    bus.obj_RGB = {8'h40, 8'h30, 8'hFF, 8'h10};
    bus.draw_requests = 4'b0110;
    tick();
    n_checks++; if (bus.out_RGB !== 8'h30) begin n_fail++; $display("FAIL transp_out got %h want 30", bus.out_RGB); end
    n_checks++; if (bus.collision_pulse !== 1'b0) begin n_fail++; $display("FAIL transp_pulse got %b want 0", bus.collision_pulse); end
    bus.obj_RGB = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.layer_enable = 4'b1011;
    tick();
    n_checks++; if (bus.out_RGB !== 8'h20) begin n_fail++; $display("FAIL mask_out got %h want 20", bus.out_RGB); end
    n_checks++; if (bus.collision_pulse !== 1'b0) begin n_fail++; $display("FAIL mask_pulse got %b want 0", bus.collision_pulse); end
    bus.draw_requests = 4'b0000;
    bus.layer_enable = 4'b1111;
    sof_tick();
    n_checks++; if (bus.frame_collisions !== 6'b000000) begin n_fail++; $display("FAIL mask_fc got %b want 000000", bus.frame_collisions); end
  endtask

  task automatic test_collision();
    int pulses;
    pulses = 0;
    bus.draw_requests = 4'b0000;
    sof_tick();
    bus.draw_requests = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      tick();
      pulses += int'(bus.collision_pulse);
    end
    bus.draw_requests = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      pulses += int'(bus.collision_pulse);
    end
    n_checks++; if (bus.frame_collisions !== 6'b000000) begin n_fail++; $display("FAIL hold_fc got %b want 000000", bus.frame_collisions); end
    sof_tick();
    pulses += int'(bus.collision_pulse);
    n_checks++; if (bus.frame_collisions !== 6'b000100) begin n_fail++; $display("FAIL pub_fc got %b want 000100", bus.frame_collisions); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL pub_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] c0;
    bus.draw_requests = 4'b0000;
    sof_tick();
    c0 = bus.frame_count;
    bus.draw_requests = 4'b0110;
    sof_tick();
    n_checks++; if (bus.frame_collisions !== 6'b001000) begin n_fail++; $display("FAIL simul_fc got %b want 001000", bus.frame_collisions); end
    n_checks++; if (bus.frame_count !== c0 + 16'd1) begin n_fail++; $display("FAIL simul_cnt got %h want %h", bus.frame_count, c0 + 16'd1); end
    n_checks++; if (bus.collision_pulse !== 1'b1) begin n_fail++; $display("FAIL simul_pulse got %b want 1", bus.collision_pulse); end
    bus.draw_requests = 4'b0000;
    tick();
    sof_tick();
    n_checks++; if (bus.frame_collisions !== 6'b001000) begin n_fail++; $display("FAIL simul_next_fc got %b want 001000", bus.frame_collisions); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      bus.draw_requests = 4'($urandom);
      bus.layer_enable = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < 4; i++) bus.obj_RGB[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      bus.background_RGB = 8'($urandom);
      bus.startOfFrame = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++; if (bus.out_RGB !== m_out) begin n_fail++; $display("FAIL rnd_out cyc %0d got %h want %h", k, bus.out_RGB, m_out); end
      n_checks++; if (bus.frame_collisions !== m_fc) begin n_fail++; $display("FAIL rnd_fc cyc %0d got %b want %b", k, bus.frame_collisions, m_fc); end
      n_checks++; if (bus.collision_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse cyc %0d got %b want %b", k, bus.collision_pulse, m_pulse); end
      n_checks++; if (bus.frame_count !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %h want %h", k, bus.frame_count, m_cnt); end
    end
    bus.startOfFrame = 1'b0;
    bus.layer_enable = 4'b1111;
    bus.obj_RGB = {8'h40, 8'h30, 8'h20, 8'h10};
  endtask

  task automatic test_reset_mid();
    bus.draw_requests = 4'b0000;
    sof_tick();
    bus.draw_requests = 4'b0011;
    tick();
    tick();
    resetN = 1'b0;
    model_clear();
    #2;
    n_checks++; if (bus.out_RGB !== 8'h00) begin n_fail++; $display("FAIL mid_out got %h want 00", bus.out_RGB); end
    n_checks++; if (bus.frame_collisions !== 6'b0) begin n_fail++; $display("FAIL mid_fc got %b want 000000", bus.frame_collisions); end
    n_checks++; if (bus.collision_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_pulse got %b want 0", bus.collision_pulse); end
    n_checks++; if (bus.frame_count !== 16'h0) begin n_fail++; $display("FAIL mid_cnt got %h want 0000", bus.frame_count); end
    bus.draw_requests = 4'b0000;
    @(posedge clk); #1;
    resetN = 1'b1;
    tick();
    sof_tick();
    n_checks++; if (bus.frame_collisions !== 6'b000000) begin n_fail++; $display("FAIL mid_pub_fc got %b want 000000", bus.frame_collisions); end
    n_checks++; if (bus.frame_count !== 16'h1) begin n_fail++; $display("FAIL mid_pub_cnt got %h want 0001", bus.frame_count); end
  endtask

  task automatic test_wrap();
    resetN = 1'b0;
    model_clear();
    #2;
    @(posedge clk); #1;
    resetN = 1'b1;
    bus.draw_requests = 4'b0000;
    bus.startOfFrame = 1'b1;
    repeat (65535) tick();
    n_checks++; if (bus.frame_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got %h want ffff", bus.frame_count); end
    tick();
    n_checks++; if (bus.frame_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", bus.frame_count); end
    n_checks++; if (bus.frame_count !== m_cnt) begin n_fail++; $display("FAIL wrap_model got %h want %h", bus.frame_count, m_cnt); end
    bus.startOfFrame = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask();
    test_collision();
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/object_compositor.md
OBJECT_COMPOSITOR -- requirements
Module: object_compositor

Interface
REQ-001 The block SHALL have parameter NUM_OBJECTS, default 4, giving the number of drawable object layers (legal range 2..16).
REQ-002 The block SHALL have parameter RGB_WIDTH, default 8, giving the colour width in bits.
REQ-003 The block SHALL have parameter TRANSPARENT_RGB, default 8'hFF, giving the colour code treated as "no pixel".
REQ-004 clk  input  1  system clock; the block SHALL use this single clock.
REQ-005 resetN  input  1  reset, asynchronous and active-low.
REQ-006 startOfFrame  input  1  single-cycle pulse marking the first pixel of a frame.
REQ-007 draw_requests  input  NUM_OBJECTS  per-layer draw request; index 0 is highest priority.
REQ-008 obj_RGB  input  NUM_OBJECTS x RGB_WIDTH  per-layer colour, same indexing as draw_requests.
REQ-009 background_RGB  input  RGB_WIDTH  colour shown when no layer wins.
REQ-010 layer_enable  input  NUM_OBJECTS  per-layer mask; 0 removes that layer from drawing and from collision detection.
REQ-011 out_RGB  output  RGB_WIDTH  registered composited pixel colour.
REQ-012 frame_collisions  output  NUM_PAIRS  collision bits for all layer pairs in the previous frame; NUM_PAIRS = NUM_OBJECTS*(NUM_OBJECTS-1)/2.
REQ-013 collision_pulse  output  1  one-cycle pulse on the first overlap of a pair within the current frame.
REQ-014 frame_count  output  16  number of completed frames.

Function
REQ-015 A layer i SHALL be active in a cycle iff draw_requests[i], layer_enable[i] and obj_RGB[i] != TRANSPARENT_RGB are all true.
REQ-016 out_RGB SHALL equal obj_RGB of the lowest-index active layer, or background_RGB if no layer is active.
REQ-017 out_RGB SHALL be registered with exactly one clk of latency from its inputs.
REQ-018 Pair (i,j), with i<j, SHALL map to bit index i*NUM_OBJECTS - i*(i+1)/2 + (j-i-1); this gives (0,1)=0 and (N-2,N-1)=NUM_PAIRS-1.
REQ-019 A pair hit SHALL occur in a cycle where layers i and j are both active.
REQ-020 A sticky accumulator SHALL OR in every pair hit of the current frame.
REQ-021 On startOfFrame, frame_collisions SHALL load the accumulator value, including any hits of that same cycle.
REQ-022 On startOfFrame, the accumulator SHALL be loaded with only the hits of that cycle, so those hits also count toward the new frame.
REQ-023 collision_pulse SHALL assert for one cycle, one clk after a hit on a pair whose accumulator bit was 0 before that cycle; several new pairs in one cycle SHALL give a single pulse.
REQ-024 frame_collisions SHALL hold its value constant between startOfFrame pulses.
REQ-025 frame_count SHALL increment by 1 on each startOfFrame and wrap from 16'hFFFF to 0.
REQ-026 Changing layer_enable mid-frame SHALL take effect from the next cycle, and SHALL NOT clear hits already accumulated.

Reset
REQ-027 While resetN is low, out_RGB, frame_collisions, the accumulator, collision_pulse and frame_count SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL discard partial-frame collisions.
REQ-029 After reset releases, the first startOfFrame SHALL publish frame_collisions = 0 unless hits occur in that cycle.

Structure
REQ-030 RGB_WIDTH default, TRANSPARENT_RGB default and the pair-index function SHALL live in shared package space_invaders_pkg.
REQ-031 Pair detection and accumulation SHALL be one sub-module, pair_collision_detect; priority selection and the output register SHALL remain in object_compositor.

Verification (NUM_OBJECTS=4, TRANSPARENT_RGB=8'hFF)
REQ-032 Priority: requests 4'b0110, obj_RGB {8'h10,8'h20,8'h30,8'h40}, background 8'h03 -> out_RGB=8'h20 one cycle later; requests 0 -> 8'h03.
REQ-033 Transparency and mask: layer 1 RGB=8'hFF with requests 4'b0110 -> out_RGB=8'h30, no (1,2) hit; layer_enable=4'b1011 with requests 4'b0110 -> out_RGB=8'h20, no hit.
REQ-034 Collision publish: layers 0 and 3 overlap once in frame N -> after the next startOfFrame, frame_collisions=6'b000100; exactly one collision_pulse.
REQ-035 Simultaneous events: a (1,2) hit in the startOfFrame cycle -> bit 3 set in the published value and set again in the next frame's result; frame_count increments once.
REQ-036 Reset and wrap: resetN low mid-frame after hits -> all outputs 0 and hits lost; 65536 startOfFrame pulses -> frame_count returns to 0.
